// File: rtl/rgb_sram_writer_pkg.sv
// Shared state types, frame constants and payload structs for the RGB SRAM writer.
// Optional feature macro used by the writer: RGB_WRITER_CLIP_EN.
package rgb_sram_writer_pkg;

    localparam int unsigned DEFAULT_IMAGE_WIDTH  = 320;
    localparam int unsigned DEFAULT_IMAGE_HEIGHT = 240;

    localparam int unsigned ADDR_W    = 18;
    localparam int unsigned PIX_CNT_W = 17;
    localparam int unsigned CHAN_IN_W = 32;
    localparam int unsigned CHAN_W    = 8;
    localparam int unsigned WORD_W    = 16;

    typedef enum logic [1:0] {
        S_RW_IDLE       = 2'd0,
        S_RW_PIX_EVEN   = 2'd1,
        S_RW_PIX_ODD    = 2'd2,
        S_RW_WRITE_LAST = 2'd3
    } RGB_writer_state_type;

    typedef struct packed {
        logic [CHAN_W-1:0] r;
        logic [CHAN_W-1:0] g;
        logic [CHAN_W-1:0] b;
    } rgb888_t;

endpackage

// File: rtl/rgb_clip8.sv
// Converts one signed 32-bit colour-space result into an 8-bit channel value.
// With RGB_WRITER_CLIP_EN the value saturates to 0..255, otherwise bits [23:16] pass through.
module rgb_clip8
    import rgb_sram_writer_pkg::*;
(
    input  logic [CHAN_IN_W-1:0] chan_i,
    output logic [CHAN_W-1:0]    chan_o
);

`ifdef RGB_WRITER_CLIP_EN
    logic unused_frac;
    assign unused_frac = ^chan_i[15:0];

    // Sign bit wins over overflow so large negatives still clamp to zero.
    always_comb begin
        chan_o = chan_i[23:16];
        if (chan_i[31]) begin
            chan_o = '0;
        end else if (|chan_i[30:24]) begin
            chan_o = '1;
        end
    end
`else
    logic unused_bits;
    assign unused_bits = ^{chan_i[31:24], chan_i[15:0]};
    assign chan_o      = chan_i[23:16];
`endif

endmodule

// File: rtl/rgb_sram_writer.sv
// Packs a stream of RGB pixels into 16-bit SRAM words, two pixels per three words.
// Channel saturation is enabled by defining RGB_WRITER_CLIP_EN.
module rgb_sram_writer
    import rgb_sram_writer_pkg::*;
#(
    parameter int unsigned IMAGE_WIDTH  = DEFAULT_IMAGE_WIDTH,
    parameter int unsigned IMAGE_HEIGHT = DEFAULT_IMAGE_HEIGHT
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    SRAM_base_address,
    input  logic                 pixel_valid,
    output logic                 pixel_ready,
    input  logic [CHAN_IN_W-1:0] R_in,
    input  logic [CHAN_IN_W-1:0] G_in,
    input  logic [CHAN_IN_W-1:0] B_in,
    output logic [ADDR_W-1:0]    SRAM_address,
    output logic [WORD_W-1:0]    SRAM_write_data,
    output logic                 SRAM_we_n,
    output logic                 done
);

    localparam logic [PIX_CNT_W-1:0] PIX_TOTAL = PIX_CNT_W'(IMAGE_WIDTH * IMAGE_HEIGHT);

    RGB_writer_state_type state_q;
    logic [ADDR_W-1:0]    next_addr_q;
    logic [ADDR_W-1:0]    next_addr_d;
    logic [PIX_CNT_W-1:0] pix_cnt_q;
    logic [PIX_CNT_W-1:0] pix_cnt_d;
    logic [CHAN_W-1:0]    b0_q;
    logic [WORD_W-1:0]    gb1_q;
    rgb888_t              pix;

    rgb_clip8 u_clip_r (.chan_i(R_in), .chan_o(pix.r));
    rgb_clip8 u_clip_g (.chan_i(G_in), .chan_o(pix.g));
    rgb_clip8 u_clip_b (.chan_i(B_in), .chan_o(pix.b));

    assign pixel_ready = (state_q == S_RW_PIX_EVEN) || (state_q == S_RW_PIX_ODD);
    assign next_addr_d = next_addr_q + ADDR_W'(1);
    assign pix_cnt_d   = pix_cnt_q + PIX_CNT_W'(1);

    // Write strobe and done default to idle every cycle; address/data hold between writes.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q         <= S_RW_IDLE;
            next_addr_q     <= '0;
            pix_cnt_q       <= '0;
            b0_q            <= '0;
            gb1_q           <= '0;
            SRAM_address    <= '0;
            SRAM_write_data <= '0;
            SRAM_we_n       <= 1'b1;
            done            <= 1'b0;
        end else begin
            SRAM_we_n <= 1'b1;
            done      <= 1'b0;
            case (state_q)
                S_RW_IDLE: begin
                    if (start) begin
                        next_addr_q <= SRAM_base_address;
                        pix_cnt_q   <= '0;
                        state_q     <= S_RW_PIX_EVEN;
                    end
                end
                S_RW_PIX_EVEN: begin
                    if (pixel_valid) begin
                        SRAM_address    <= next_addr_q;
                        SRAM_write_data <= {pix.r, pix.g};
                        SRAM_we_n       <= 1'b0;
                        next_addr_q     <= next_addr_d;
                        b0_q            <= pix.b;
                        pix_cnt_q       <= pix_cnt_d;
                        state_q         <= S_RW_PIX_ODD;
                    end
                end
                S_RW_PIX_ODD: begin
                    if (pixel_valid) begin
                        SRAM_address    <= next_addr_q;
                        SRAM_write_data <= {b0_q, pix.r};
                        SRAM_we_n       <= 1'b0;
                        next_addr_q     <= next_addr_d;
                        gb1_q           <= {pix.g, pix.b};
                        pix_cnt_q       <= pix_cnt_d;
                        state_q         <= S_RW_WRITE_LAST;
                    end
                end
                S_RW_WRITE_LAST: begin
                    SRAM_address    <= next_addr_q;
                    SRAM_write_data <= gb1_q;
                    SRAM_we_n       <= 1'b0;
                    next_addr_q     <= next_addr_d;
                    if (pix_cnt_q == PIX_TOTAL) begin
                        done    <= 1'b1;
                        state_q <= S_RW_IDLE;
                    end else begin
                        state_q <= S_RW_PIX_EVEN;
                    end
                end
                default: state_q <= S_RW_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rgb_sram_writer.sv
// Self-checking bench for rgb_sram_writer using a byte-stream packing reference model.
// Expected channel values follow RGB_WRITER_CLIP_EN when it is defined for the build.
module tb_rgb_sram_writer;

    localparam int unsigned TB_W  = 16;
    localparam int unsigned TB_H  = 8;
    localparam int unsigned WORDS = 3 * TB_W * TB_H / 2;

    typedef struct {
        logic [17:0] addr;
        logic [15:0] data;
        logic        last;
    } wr_t;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b1;
    logic        start = 1'b0;
    logic [17:0] SRAM_base_address = '0;
    logic        pixel_valid = 1'b0;
    logic        pixel_ready;
    logic [31:0] R_in = '0, G_in = '0, B_in = '0;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic        done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int first_acc_cyc = -1;
    bit mon_en = 1'b0;

    logic [17:0] base_m;
    int          word_idx;
    logic [7:0]  bq[$];
    wr_t         expq[$];
    wr_t         wlog[$];

    rgb_sram_writer #(.IMAGE_WIDTH(TB_W), .IMAGE_HEIGHT(TB_H)) dut (
        .Clock(Clock), .Resetn(Resetn), .start(start),
        .SRAM_base_address(SRAM_base_address),
        .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
        .R_in(R_in), .G_in(G_in), .B_in(B_in),
        .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data),
        .SRAM_we_n(SRAM_we_n), .done(done)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc++;

    function automatic logic [7:0] chan(input logic [31:0] v);
`ifdef RGB_WRITER_CLIP_EN
        if ($signed(v) < 0) return 8'd0;
        if ($signed(v) > 32'sh00FFFFFF) return 8'd255;
`endif
        return v[23:16];
    endfunction

    function automatic logic [31:0] rnd_ch();
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(0, 1) == 0) v = {8'h00, 8'($urandom), 16'($urandom)};
        return v;
    endfunction

    // Reference: the frame is a byte stream R,G,B,R,G,B,... cut into big-endian 16-bit words.
    task automatic model_start(input logic [17:0] base);
        base_m = base;
        word_idx = 0;
        bq.delete();
        first_acc_cyc = -1;
    endtask

    task automatic model_pixel(input logic [31:0] r, input logic [31:0] g, input logic [31:0] b);
        wr_t w;
        bq.push_back(chan(r));
        bq.push_back(chan(g));
        bq.push_back(chan(b));
        while (bq.size() >= 2) begin
            w.addr = base_m + 18'(word_idx);
            w.data[15:8] = bq.pop_front();
            w.data[7:0] = bq.pop_front();
            w.last = (word_idx == int'(WORDS) - 1);
            expq.push_back(w);
            word_idx++;
        end
    endtask

    // Write monitor: every strobe must match the next expected word, done only on the last one.
    always @(negedge Clock) begin
        if (mon_en && Resetn) begin
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (SRAM_we_n === 1'b0) begin
                wr_t e, o;
                o.addr = SRAM_address;
                o.data = SRAM_write_data;
                o.last = done;
                wlog.push_back(o);
                checks++;
                assert (expq.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_write observed=%h@%h expected=none", SRAM_write_data, SRAM_address);
                end
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    checks++;
                    assert (SRAM_address === e.addr) else begin
                        errors++;
                        $error("FAIL wr_addr observed=%h expected=%h", SRAM_address, e.addr);
                    end
                    checks++;
                    assert (SRAM_write_data === e.data) else begin
                        errors++;
                        $error("FAIL wr_data observed=%h expected=%h", SRAM_write_data, e.data);
                    end
                    checks++;
                    assert (done === e.last) else begin
                        errors++;
                        $error("FAIL wr_done observed=%b expected=%b", done, e.last);
                    end
                end
            end else begin
                checks++;
                assert (done === 1'b0) else begin
                    errors++;
                    $error("FAIL done_no_write observed=%b expected=0", done);
                end
                checks++;
                assert (SRAM_we_n === 1'b1) else begin
                    errors++;
                    $error("FAIL we_n_known observed=%b expected=1", SRAM_we_n);
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge Clock);
        #2 Resetn = 1'b0;
        #1;
        check_eq("rst_we_n", 32'(SRAM_we_n), 32'd1);
        check_eq("rst_addr", 32'(SRAM_address), 32'd0);
        check_eq("rst_data", 32'(SRAM_write_data), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_ready", 32'(pixel_ready), 32'd0);
        expq.delete();
        bq.delete();
        wlog.delete();
        done_cnt = 0;
        @(posedge Clock);
        #1 Resetn = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic pulse_start(input logic [17:0] base, input bit expect_idle);
        SRAM_base_address = base;
        start = 1'b1;
        if (expect_idle) model_start(base);
        @(posedge Clock);
        #1 start = 1'b0;
    endtask

    // Presents one pixel and holds it until the handshake completes (bounded).
    task automatic send_pixel(input logic [31:0] r, input logic [31:0] g, input logic [31:0] b);
        bit acc;
        acc = 1'b0;
        R_in = r;
        G_in = g;
        B_in = b;
        pixel_valid = 1'b1;
        for (int t = 0; t < 10 && !acc; t++) begin
            if (pixel_ready === 1'b1) begin
                acc = 1'b1;
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
            end
            @(posedge Clock);
            #1;
        end
        checks++;
        assert (acc) else begin
            errors++;
            $error("FAIL pixel_accept observed=0 expected=1");
        end
        if (acc) model_pixel(r, g, b);
    endtask

    task automatic idle_cycles(input int n);
        pixel_valid = 1'b0;
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic wait_done();
        for (int t = 0; t < 20 && done_cnt == 0; t++) begin
            @(posedge Clock);
            #1;
        end
        idle_cycles(4);
    endtask

    initial begin
        logic [15:0] exp_rg;
        logic [17:0] base;
        #1 Resetn = 1'b0;
        do_reset();

        // Two known pixels from base 0.
        pulse_start(18'd0, 1'b1);
        send_pixel(32'h0012_0000, 32'h0034_0000, 32'h0056_0000);
        send_pixel(32'h0078_0000, 32'h009A_0000, 32'h00BC_0000);
        idle_cycles(4);
        check_eq("t1_nwrites", 32'(wlog.size()), 32'd3);
        if (wlog.size() == 3) begin
            check_eq("t1_w0", {14'd0, wlog[0].addr, wlog[0].data} >> 16, 32'd0);
            check_eq("t1_d0", 32'(wlog[0].data), 32'h1234);
            check_eq("t1_d1", 32'(wlog[1].data), 32'h5678);
            check_eq("t1_a2", 32'(wlog[2].addr), 32'd2);
            check_eq("t1_d2", 32'(wlog[2].data), 32'h9ABC);
        end
        check_eq("t1_drain", 32'(expq.size()), 32'd0);

        // Stall between even and odd pixel, then the saturation corner values.
        do_reset();
        pulse_start(18'd50, 1'b1);
        send_pixel(rnd_ch(), rnd_ch(), rnd_ch());
        pixel_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge Clock);
            #1;
            check_eq("gap_ready", 32'(pixel_ready), 32'd1);
        end
        check_eq("gap_nwrites", 32'(wlog.size()), 32'd1);
        send_pixel(rnd_ch(), rnd_ch(), rnd_ch());
        send_pixel(32'hFFFF_FFFB, 32'h0120_0000, 32'h00FF_0000);
        send_pixel(32'h00AB_0000, 32'h00AB_0000, 32'h00AB_0000);
        idle_cycles(4);
`ifdef RGB_WRITER_CLIP_EN
        exp_rg = 16'h00FF;
`else
        exp_rg = 16'hFF20;
`endif
        check_eq("clip_nwrites", 32'(wlog.size()), 32'd6);
        if (wlog.size() == 6) begin
            check_eq("clip_rg", 32'(wlog[3].data), 32'(exp_rg));
            check_eq("clip_br", 32'(wlog[4].data), 32'hFFAB);
            check_eq("clip_addr", 32'(wlog[3].addr), 32'd53);
        end

        // Full frame with continuous valid and a stray start mid-frame.
        do_reset();
        base = 18'h20000;
        pulse_start(base, 1'b1);
        for (int i = 0; i < int'(TB_W * TB_H); i++) begin
            start = (i == 40);
            send_pixel(rnd_ch(), rnd_ch(), rnd_ch());
        end
        start = 1'b0;
        wait_done();
        check_eq("ff_nwrites", 32'(wlog.size()), 32'(WORDS));
        check_eq("ff_done_cnt", 32'(done_cnt), 32'd1);
        check_eq("ff_latency", 32'(done_cyc - first_acc_cyc), 32'(WORDS));
        if (wlog.size() != 0) check_eq("ff_last_addr", 32'(wlog[wlog.size()-1].addr), 32'(base) + 32'(WORDS) - 32'd1);
        check_eq("ff_idle_ready", 32'(pixel_ready), 32'd0);
        check_eq("ff_drain", 32'(expq.size()), 32'd0);

        // Reset after 100 pixels abandons the frame; next frame starts clean at 1000.
        do_reset();
        pulse_start(18'd7, 1'b1);
        for (int i = 0; i < 100; i++) send_pixel(rnd_ch(), rnd_ch(), rnd_ch());
        idle_cycles(3);
        check_eq("mid_drain", 32'(expq.size()), 32'd0);
        do_reset();
        R_in = 32'h0011_0000;
        pixel_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge Clock);
            #1;
            check_eq("post_rst_ready", 32'(pixel_ready), 32'd0);
        end
        check_eq("post_rst_nwrites", 32'(wlog.size()), 32'd0);
        pulse_start(18'd1000, 1'b1);
        for (int i = 0; i < int'(TB_W * TB_H); i++) begin
            send_pixel(rnd_ch(), rnd_ch(), rnd_ch());
            if ($urandom_range(0, 7) == 0) idle_cycles(1);
        end
        wait_done();
        check_eq("rs_nwrites", 32'(wlog.size()), 32'(WORDS));
        if (wlog.size() != 0) check_eq("rs_first_addr", 32'(wlog[0].addr), 32'd1000);
        check_eq("rs_done_cnt", 32'(done_cnt), 32'd1);
        check_eq("rs_drain", 32'(expq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
